input_port: RTL and testbench

// - Synthesizable input register stage between the keyboard source and the CPU: holds INPR, drives FGI.
// - Accepts characters over a 4-phase load/ack handshake into a small FIFO.
// - The CPU sees the FIFO head as INPR and FGI=non-empty; the INP instruction's FGI-clear pops one entry.
// - Lets fast typists or file-driven input run ahead of the program without dropping characters.

---
 rtl/mano_io_pkg.sv | 6 +
 rtl/io_sync_fifo.sv | 47 ++++
 rtl/input_port.sv | 77 +++++++
 tb/tb_input_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mano_io_pkg.sv
// Shared types for the Mano-style I/O registers: character type, keyboard handshake states.
package mano_io_pkg;
   typedef logic [7:0] char_t;
   typedef enum logic {KBD_IDLE, KBD_ACK} kbd_state_e;
   localparam char_t CHAR_NONE = 8'h00;
endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock character FIFO; push/pop must already be qualified by the caller.
// The occupancy counter is the only full/empty source; the head reads CHAR_NONE when empty.
module io_sync_fifo
   import mano_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               data_in,
   output logic [7:0]               head_out,
   output logic [$clog2(DEPTH):0]   count_out
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage carries no reset; stale entries are hidden by the count gate on the head.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_out <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_out <= count_out + 1'b1;
            2'b01:   count_out <= count_out - 1'b1;
            default: count_out <= count_out;
         endcase
      end
   end

   assign head_out = (count_out != '0) ? mem[rd_ptr] : CHAR_NONE;
endmodule

// File: rtl/input_port.sv
// Keyboard input register (INPR/FGI) with a 4-phase load/ack handshake feeding a FIFO.
// Define INPUT_IRQ_EN to add the ien_in/irq_out interrupt register.
module input_port
   import mano_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               data_in,
   input  logic                     load_in,
   output logic                     ack_out,
   output logic [7:0]               inpr_out,
   output logic                     fgi_out,
   input  logic                     clear_fgi_in,
   output logic [$clog2(DEPTH):0]   count_out
`ifdef INPUT_IRQ_EN
   ,
   input  logic                     ien_in,
   output logic                     irq_out
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;

   kbd_state_e state;
   logic       full;
   logic       push;
   logic       pop;

   assign full    = (count_out == CW'(DEPTH));
   assign fgi_out = (count_out != '0);
   // Only IDLE may push, so a held load_in is taken exactly once.
   assign push    = (state == KBD_IDLE) && load_in && !full;
   assign pop     = clear_fgi_in && fgi_out;

   io_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .data_in   (data_in),
      .head_out  (inpr_out),
      .count_out (count_out)
   );

   // ACK is held while full so the keyboard sees busy until a slot frees up.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= KBD_IDLE;
         ack_out <= 1'b0;
      end else begin
         case (state)
            KBD_IDLE: if (push) begin
               state   <= KBD_ACK;
               ack_out <= 1'b1;
            end
            KBD_ACK: if (!load_in && !full) begin
               state   <= KBD_IDLE;
               ack_out <= 1'b0;
            end
            default: begin
               state   <= KBD_IDLE;
               ack_out <= 1'b0;
            end
         endcase
      end
   end

`ifdef INPUT_IRQ_EN
   always_ff @(posedge clock) begin
      if (reset)
         irq_out <= 1'b0;
      else
         irq_out <= fgi_out & ien_in;
   end
`endif
endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: constant vector table, hand sequences, then random traffic vs a queue model.
module tb_input_port;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       load_in;
   logic       ack_out;
   logic [7:0] inpr_out;
   logic       fgi_out;
   logic       clear_fgi_in;
   logic [2:0] count_out;
`ifdef INPUT_IRQ_EN
   logic       ien_in;
   logic       irq_out;
   logic       irq_m;
`endif

   int errors = 0;
   int checks = 0;

   // Reference: list of characters in arrival order plus "this request already taken" flag.
   logic [7:0] q[$];
   logic       served;

   input_port #(.DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .data_in      (data_in),
      .load_in      (load_in),
      .ack_out      (ack_out),
      .inpr_out     (inpr_out),
      .fgi_out      (fgi_out),
      .clear_fgi_in (clear_fgi_in),
      .count_out    (count_out)
`ifdef INPUT_IRQ_EN
      ,
      .ien_in       (ien_in),
      .irq_out      (irq_out)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       load;
      logic [7:0] data;
      logic       clr;
      logic       ack;
      logic       fgi;
      logic [7:0] inpr;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic load, logic [7:0] data, logic clr,
                               logic ack, logic fgi, logic [7:0] inpr, logic [2:0] cnt);
      vec_t v;
      v.rst = rst; v.load = load; v.data = data; v.clr = clr;
      v.ack = ack; v.fgi = fgi; v.inpr = inpr; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int sz;
      logic do_pop;
      logic do_push;
      logic [7:0] tmp;
      if (reset) begin
         q.delete();
         served = 1'b0;
`ifdef INPUT_IRQ_EN
         irq_m = 1'b0;
`endif
      end else begin
         sz      = q.size();
         do_pop  = clear_fgi_in && (sz > 0);
         do_push = load_in && !served && (sz < DEPTH);
`ifdef INPUT_IRQ_EN
         irq_m = (sz > 0) && ien_in;
`endif
         if (do_push)
            served = 1'b1;
         else if (served && !load_in && sz < DEPTH)
            served = 1'b0;
         if (do_pop) tmp = q.pop_front();
         if (do_push) q.push_back(data_in);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic expect_out(input string tag, input logic ack, input logic fgi,
                             input logic [7:0] inpr, input logic [2:0] cnt);
      check({tag, ".ack"},   {31'd0, ack_out}, {31'd0, ack});
      check({tag, ".fgi"},   {31'd0, fgi_out}, {31'd0, fgi});
      check({tag, ".inpr"},  {24'd0, inpr_out}, {24'd0, inpr});
      check({tag, ".count"}, {29'd0, count_out}, {29'd0, cnt});
   endtask

   task automatic expect_model(input string tag);
      expect_out(tag, served, q.size() > 0, (q.size() > 0) ? q[0] : 8'h00, 3'(q.size()));
`ifdef INPUT_IRQ_EN
      check({tag, ".irq"}, {31'd0, irq_out}, {31'd0, irq_m});
`endif
   endtask

   task automatic drive(input logic rst, input logic load, input logic [7:0] data, input logic clr);
      reset = rst; load_in = load; data_in = data; clear_fgi_in = clr;
   endtask

   initial begin
      logic [7:0] seen[$];
      logic [7:0] want[$];
      drive(1'b1, 1'b0, 8'h00, 1'b0);
`ifdef INPUT_IRQ_EN
      ien_in = 1'b0;
`endif
      served = 1'b0;

      // ---------------- vector table ----------------
      tbl.push_back(mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 3'd0));
      tbl.push_back(mk(0, 1, 8'h41, 0,  1, 1, 8'h41, 3'd1));
      tbl.push_back(mk(0, 0, 8'h00, 0,  0, 1, 8'h41, 3'd1));
      tbl.push_back(mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 3'd0));
      tbl.push_back(mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 3'd0));
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(0, 1, 8'h33, 0,  1, 1, 8'h33, 3'd1));
      tbl.push_back(mk(0, 0, 8'h00, 0,  0, 1, 8'h33, 3'd1));
      tbl.push_back(mk(0, 1, 8'h34, 0,  1, 1, 8'h33, 3'd2));
      tbl.push_back(mk(0, 0, 8'h00, 0,  0, 1, 8'h33, 3'd2));
      tbl.push_back(mk(0, 1, 8'h35, 1,  1, 1, 8'h34, 3'd2));
      tbl.push_back(mk(0, 0, 8'h00, 0,  0, 1, 8'h34, 3'd2));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].load, tbl[i].data, tbl[i].clr);
         cycle();
         expect_out($sformatf("vec%0d", i), tbl[i].ack, tbl[i].fgi, tbl[i].inpr, tbl[i].cnt);
      end

      // ---------------- fill to full, blocked 5th, order a..e ----------------
      drive(1'b1, 1'b0, 8'h00, 1'b0); cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'h61 + 8'(i), 1'b0); cycle();
         drive(1'b0, 1'b0, 8'h00, 1'b0); cycle();
      end
      expect_out("full", 1'b1, 1'b1, 8'h61, 3'd4);
      drive(1'b0, 1'b1, 8'h65, 1'b0); cycle(); cycle();
      expect_out("blocked_e", 1'b1, 1'b1, 8'h61, 3'd4);
      seen.push_back(inpr_out);
      drive(1'b0, 1'b0, 8'h00, 1'b1); cycle();
      expect_out("pop_full", 1'b1, 1'b1, 8'h62, 3'd3);
      drive(1'b0, 1'b0, 8'h00, 1'b0); cycle();
      expect_out("ack_release", 1'b0, 1'b1, 8'h62, 3'd3);
      drive(1'b0, 1'b1, 8'h65, 1'b0); cycle();
      expect_out("push_e", 1'b1, 1'b1, 8'h62, 3'd4);
      drive(1'b0, 1'b0, 8'h00, 1'b0); cycle();
      for (int i = 0; i < 5; i++) begin
         if (fgi_out) seen.push_back(inpr_out);
         drive(1'b0, 1'b0, 8'h00, 1'b1); cycle();
      end
      expect_out("drained", 1'b0, 1'b0, 8'h00, 3'd0);
      want = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      check("order.len", 32'(seen.size()), 32'd5);
      foreach (want[i])
         if (i < seen.size()) check($sformatf("order%0d", i), {24'd0, seen[i]}, {24'd0, want[i]});

      // ---------------- reset while in ACK with 3 entries ----------------
      drive(1'b0, 1'b0, 8'h00, 1'b0); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0); cycle();
         if (i < 2) begin drive(1'b0, 1'b0, 8'h00, 1'b0); cycle(); end
      end
      expect_out("pre_rst", 1'b1, 1'b1, 8'h70, 3'd3);
      drive(1'b1, 1'b0, 8'h00, 1'b0); cycle();
      expect_out("rst_ack", 1'b0, 1'b0, 8'h00, 3'd0);

`ifdef INPUT_IRQ_EN
      // ---------------- interrupt timing ----------------
      drive(1'b0, 1'b1, 8'h55, 1'b0); ien_in = 1'b1; cycle();
      check("irq_lag0", {31'd0, irq_out}, 32'd0);
      drive(1'b0, 1'b0, 8'h00, 1'b0); cycle();
      check("irq_rise", {31'd0, irq_out}, 32'd1);
      ien_in = 1'b0; cycle();
      check("irq_ien0", {31'd0, irq_out}, 32'd0);
      ien_in = 1'b1; cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1); cycle();
      check("irq_fall_lag", {31'd0, irq_out}, 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b0); cycle();
      check("irq_fall", {31'd0, irq_out}, 32'd0);
      ien_in = 1'b0;
`endif

      // ---------------- random traffic against the queue model ----------------
      drive(1'b1, 1'b0, 8'h00, 1'b0); cycle();
      expect_model("rnd_rst");
      for (int n = 0; n < 800; n++) begin
         if (load_in) load_in = ($urandom_range(0, 9) < 7);
         else         load_in = ($urandom_range(0, 9) < 4);
         data_in      = 8'($urandom);
         clear_fgi_in = ($urandom_range(0, 9) < 3);
         reset        = ($urandom_range(0, 99) == 0);
`ifdef INPUT_IRQ_EN
         ien_in       = 1'($urandom);
`endif
         cycle();
         expect_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
